// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use detection.
// The EX/MEM and MEM/WB bypass muxes sit after the register, so they see the current downstream state.

module id_ex_fwd #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic [RAW-1:0]  src_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exmem_regwrite,
  input  logic [RAW-1:0]  exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [RAW-1:0]  memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);
  // x0 is hard-wired zero, so a producer naming it must never be bypassed.
  always_comb begin
    fwd_data = reg_data;
    if (src_addr == '0)
      fwd_data = reg_data;
    else if (exmem_regwrite && exmem_rd == src_addr)
      fwd_data = exmem_result;
    else if (memwb_regwrite && memwb_rd == src_addr)
      fwd_data = memwb_result;
  end
endmodule

module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RAW    = 5,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [RAW-1:0]    id_rs1_addr,
  input  logic [RAW-1:0]    id_rs2_addr,
  input  logic [RAW-1:0]    id_rd_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alusrc,
  input  logic [ALUOPW-1:0] id_aluop,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              exmem_regwrite,
  input  logic [RAW-1:0]    exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_regwrite,
  input  logic [RAW-1:0]    memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [ALUOPW-1:0] alu_aluop,
  output logic [XLEN-1:0]   ex_store_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [RAW-1:0]    ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              load_use_hazard
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic [ALUOPW-1:0] aluop;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } ctrl_t;

  ctrl_t                       id_ctrl, ex_ctrl;
  logic [XLEN-1:0]             ex_imm;
  logic [NSRC-1:0][RAW-1:0]    id_rs_addr, ex_rs_addr;
  logic [NSRC-1:0][XLEN-1:0]   id_rs_data, ex_rs_data, fwd_data;

  assign id_ctrl    = '{valid: id_valid, alusrc: id_alusrc, aluop: id_aluop,
                        regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite};
  assign id_rs_addr = {id_rs2_addr, id_rs1_addr};
  assign id_rs_data = {id_rs2_data, id_rs1_data};

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    id_ex_fwd #(.XLEN(XLEN), .RAW(RAW)) u_fwd (
      .src_addr       (ex_rs_addr[i]),
      .reg_data       (ex_rs_data[i]),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .fwd_data       (fwd_data[i])
    );
  end

  // On stall the operand registers capture the bypassed value, so a MEM/WB
  // result survives after that instruction leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rd      <= '0;
      ex_imm     <= '0;
      ex_rs_addr <= '0;
      ex_rs_data <= '0;
    end else if (flush) begin
      ex_ctrl    <= '0;
    end else if (stall) begin
      ex_rs_data <= fwd_data;
    end else begin
      ex_ctrl    <= id_ctrl;
      ex_pc      <= id_pc;
      ex_rd      <= id_rd_addr;
      ex_imm     <= id_imm;
      ex_rs_addr <= id_rs_addr;
      ex_rs_data <= id_rs_data;
    end
  end

  assign ex_valid      = ex_ctrl.valid;
  assign alu_aluop     = ex_ctrl.aluop;
  assign ex_regwrite   = ex_ctrl.regwrite & ex_ctrl.valid;
  assign ex_memread    = ex_ctrl.memread  & ex_ctrl.valid;
  assign ex_memwrite   = ex_ctrl.memwrite & ex_ctrl.valid;
  assign alu_a         = fwd_data[0];
  assign alu_b         = ex_ctrl.alusrc ? ex_imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];

  assign load_use_hazard = ex_ctrl.valid & ex_ctrl.memread & (ex_rd != '0) & id_valid &
                           ((ex_rd == id_rs1_addr) | (ex_rd == id_rs2_addr));
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand sequences for stall, flush and reset.
module tb_id_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
  logic [2:0]  id_aluop;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [2:0]  alu_aluop;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard;
  logic [4:0]  ex_rd;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .load_use_hazard(load_use_hazard)
  );

  typedef struct {
    logic stall, flush, vld;
    logic [31:0] pc;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic alusrc;
    logic [2:0] op;
    logic rw, mr, mw;
    logic xrw; logic [4:0] xrd; logic [31:0] xres;
    logic wrw; logic [4:0] wrd; logic [31:0] wres;
    logic [31:0] a, b, sd;
    logic [2:0] eop;
    logic v, erw, emr, emw;
    logic [4:0] erd;
    logic [31:0] epc;
    logic luh;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; id_valid = v.vld; id_pc = v.pc;
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_rd_addr = v.rd;
    id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm; id_alusrc = v.alusrc;
    id_aluop = v.op; id_regwrite = v.rw; id_memread = v.mr; id_memwrite = v.mw;
    exmem_regwrite = v.xrw; exmem_rd = v.xrd; exmem_result = v.xres;
    memwb_regwrite = v.wrw; memwb_rd = v.wrd; memwb_result = v.wres;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    vec_t z;
    z = '{0,0,0,0,0,0,0,0,0,0,0,3'd0,0,0,0, 0,0,0, 0,0,0, 0,0,0,3'd0,0,0,0,0,0,0,0};
    drive(z);
  endtask

  initial begin
    //           stl fl v  pc     rs1 rs2 rd d1      d2    imm          src op   rw mr mw  xrw xrd xres     wrw wrd wres     a        b             sd     eop  v erw emr emw erd epc    luh
    vecs[0] = '{0,0,1,32'h100, 5,  6,  1, 10,     20,   0,           0, 3'd0, 1,0,0, 1, 5,  99,      0, 0,  0,       99,      20,           20,    3'd0,1,1,0,0, 1, 32'h100,0};
    vecs[1] = '{0,0,1,32'h104, 7,  8,  2, 3,      4,    0,           0, 3'd1, 1,0,0, 1, 7,  1,       1, 7,  2,       1,       4,            4,     3'd1,1,1,0,0, 2, 32'h104,0};
    vecs[2] = '{0,0,1,32'h108, 0,  0,  3, 0,      0,    32'hFFFFFFF0,1, 3'd2, 1,0,0, 1, 0,  55,      1, 0,  66,      0,       32'hFFFFFFF0, 0,     3'd2,1,1,0,0, 3, 32'h108,0};
    vecs[3] = '{0,0,1,32'h10C, 9,  10, 0, 32'h11, 32'h22,32'h40,     1, 3'd3, 0,0,1, 0, 10, 32'hDEAD,1, 10, 32'h77,  32'h11,  32'h40,       32'h77,3'd3,1,0,0,1, 0, 32'h10C,0};
    vecs[4] = '{0,0,1,32'h110, 2,  0,  4, 32'h1000,0,   8,           1, 3'd0, 1,1,0, 0, 0,  0,       0, 0,  0,       32'h1000,8,            0,     3'd0,1,1,1,0, 4, 32'h110,0};
    vecs[5] = '{0,0,1,32'h114, 12, 13, 5, 1,      2,    0,           0, 3'd1, 1,0,0, 1, 13, 32'h500, 1, 12, 32'h600, 32'h600, 32'h500,      32'h500,3'd1,1,1,0,0,5, 32'h114,0};
    vecs[6] = '{0,0,0,32'h118, 1,  2,  6, 5,      6,    0,           0, 3'd0, 1,0,0, 0, 0,  0,       0, 0,  0,       5,       6,            6,     3'd0,0,0,0,0, 6, 32'h118,0};

    idle_inputs();
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_ctrl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 0);
    chk("rst_aluop", {29'd0, alu_aluop}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_store", ex_store_data, 0);
    chk("rst_rd", {27'd0, ex_rd}, 0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].sd);
      chk($sformatf("v%0d_aluop", i), {29'd0, alu_aluop}, {29'd0, vecs[i].eop});
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].v});
      chk($sformatf("v%0d_ctrl", i), {29'd0, ex_regwrite, ex_memread, ex_memwrite},
          {29'd0, vecs[i].erw, vecs[i].emr, vecs[i].emw});
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].erd});
      chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].epc);
      chk($sformatf("v%0d_luh", i), {31'd0, load_use_hazard}, {31'd0, vecs[i].luh});
    end

    // MEM/WB operand held across a 3-cycle stall after MEM/WB retires
    idle_inputs();
    id_valid = 1; id_pc = 32'h200; id_rs2_addr = 3; id_rs2_data = 32'h1111; id_rd_addr = 9;
    id_aluop = 3'd3; id_regwrite = 1;
    memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hABCD;
    tick();
    chk("fwd_wb_b", alu_b, 32'hABCD);
    stall = 1;
    id_pc = 32'h300; id_rd_addr = 15; id_aluop = 3'd1; id_rs2_data = 32'h2222;
    for (int c = 0; c < 3; c++) begin
      tick();
      memwb_regwrite = 0;
      #1;
      chk($sformatf("stall%0d_b", c), alu_b, 32'hABCD);
      chk($sformatf("stall%0d_pc", c), ex_pc, 32'h200);
      chk($sformatf("stall%0d_rd", c), {27'd0, ex_rd}, 9);
      chk($sformatf("stall%0d_op", c), {29'd0, alu_aluop}, 3);
    end

    // Load-use detection and flush bubble
    idle_inputs();
    id_valid = 1; id_pc = 32'h400; id_rd_addr = 4; id_rs1_addr = 2; id_alusrc = 1;
    id_regwrite = 1; id_memread = 1;
    tick();
    id_rd_addr = 8; id_rs1_addr = 4; id_memread = 0; #1;
    chk("luh_set", {31'd0, load_use_hazard}, 1);
    flush = 1; stall = 1;
    tick();
    chk("luh_flush_v", {31'd0, ex_valid}, 0);
    chk("luh_flush_ctl", {30'd0, ex_regwrite, ex_memread}, 0);
    chk("luh_after", {31'd0, load_use_hazard}, 0);
    flush = 0; stall = 0;
    id_rd_addr = 0; id_rs1_addr = 0; id_memread = 1;
    tick();
    chk("ld_x0_mr", {30'd0, ex_valid, ex_memread}, 3);
    chk("luh_x0", {31'd0, load_use_hazard}, 0);

    // Flush wins over stall on a store
    idle_inputs();
    id_valid = 1; id_pc = 32'h500; id_rs1_addr = 1; id_rs2_addr = 2; id_memwrite = 1; id_alusrc = 1;
    tick();
    chk("sw_mw", {30'd0, ex_valid, ex_memwrite}, 3);
    flush = 1; stall = 1;
    tick();
    chk("sw_bubble", {30'd0, ex_valid, ex_memwrite}, 0);

    // Asynchronous reset between edges
    idle_inputs();
    id_valid = 1; id_pc = 32'h600; id_rs1_addr = 7; id_rs2_addr = 8; id_rs1_data = 32'h77;
    id_rs2_data = 32'h88; id_aluop = 3'd2; id_regwrite = 1; id_memwrite = 1;
    tick();
    chk("pre_rst_a", alu_a, 32'h77);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {28'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite}, 0);
    chk("arst_op", {29'd0, alu_aluop}, 0);
    chk("arst_a", alu_a, 0);
    chk("arst_b", alu_b, 0);
    #2 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
